// File: rtl/axis_accum_scheduler_pkg.sv
// Shared definitions for the axis accumulate scheduler.
//   state_t : sequencer states (IDLE, WAIT_SMP, ACC_X, ACC_Y, ACC_Z, DONE)
//   axis_t  : axis index used to steer the shared accumulator (AX_X/AX_Y/AX_Z)
//   DEF_*   : default clamp limit and increment shift
// Optional feature macro: AXIS_DEADBAND_EN (consumed by sat_accum).
package axis_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SMP,
        ACC_X,
        ACC_Y,
        ACC_Z,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        AX_X = 2'd0,
        AX_Y = 2'd1,
        AX_Z = 2'd2
    } axis_t;

    localparam int DEF_LIMIT = 500;
    localparam int DEF_SHIFT = 8;

endpackage

// File: rtl/axis_accum_scheduler_if.sv
// Sample-triple handshake between the accelerometer front end and the
// accumulate scheduler.
//   x_axis/y_axis/z_axis : signed 16-bit samples (front end -> block)
//   sample_valid         : triple valid            (front end -> block)
//   sample_ready         : block accepting a triple (block -> front end)
// Modports: master = front end, slave = scheduler.
interface axis_accum_scheduler_if;

    logic signed [15:0] x_axis;
    logic signed [15:0] y_axis;
    logic signed [15:0] z_axis;
    logic               sample_valid;
    logic               sample_ready;

    modport master (
        output x_axis,
        output y_axis,
        output z_axis,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  x_axis,
        input  y_axis,
        input  z_axis,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/axis_accum_scheduler_sat_accum.sv
// sat_accum: combinational shift + optional dead zone + add + symmetric clamp.
// One instance is shared by all three axes.
//   pos_i    : current position (signed P_COUNT_W)
//   sample_i : raw sample slice (signed P_COUNT_W)
//   pos_o    : clamped new position (signed P_COUNT_W)
// Macro AXIS_DEADBAND_EN: when defined, increments with |inc| <= P_DEADBAND
// are forced to zero before the add.
module sat_accum #(
    parameter int P_COUNT_W  = 16,
    parameter int P_SHIFT    = 8,
    parameter int P_LIMIT    = 500,
    parameter int P_DEADBAND = 2
) (
    input  logic signed [P_COUNT_W-1:0] pos_i,
    input  logic signed [P_COUNT_W-1:0] sample_i,
    output logic signed [P_COUNT_W-1:0] pos_o
);

`ifdef AXIS_DEADBAND_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    // One extra bit of headroom so pos + inc can never wrap before the clamp.
    logic signed [P_COUNT_W:0] smp_ext;
    logic signed [P_COUNT_W:0] pos_ext;
    logic signed [P_COUNT_W:0] inc_raw;
    logic signed [P_COUNT_W:0] inc;
    logic signed [P_COUNT_W:0] sum;

    assign smp_ext = {sample_i[P_COUNT_W-1], sample_i};
    assign pos_ext = {pos_i[P_COUNT_W-1], pos_i};
    assign inc_raw = smp_ext >>> P_SHIFT;

    // Dead zone suppresses slow drift from a sensor that never sits at exactly zero.
    always_comb begin
        inc = inc_raw;
        if (DB_ON && (int'(inc_raw) <= P_DEADBAND) && (int'(inc_raw) >= -P_DEADBAND)) begin
            inc = '0;
        end
    end

    assign sum = pos_ext + inc;

    always_comb begin
        if (int'(sum) > P_LIMIT) begin
            pos_o = P_COUNT_W'(P_LIMIT);
        end else if (int'(sum) < -P_LIMIT) begin
            pos_o = P_COUNT_W'(-P_LIMIT);
        end else begin
            pos_o = sum[P_COUNT_W-1:0];
        end
    end

endmodule

// File: rtl/axis_accum_scheduler.sv
// axis_accum_scheduler: on each programmable tick, fetches one X/Y/Z sample
// triple over a valid/ready handshake and runs the three axes one after the
// other through a single saturating accumulator, producing clamped positions.
// Ports:
//   clk_in, rst_in (async, active-high), tick_div_in (period-1), clr_in
//   smp_if (slave)   : sample triple handshake
//   pos_x/y/z_out    : clamped signed positions
//   tick_out         : 1-cycle tick pulse
//   upd_valid_out    : 1-cycle pulse once all three positions are updated
//   busy_out         : sequencer not idle
//   overrun_out      : sticky, a tick arrived while busy
// Macro AXIS_DEADBAND_EN enables the increment dead zone in sat_accum.
module axis_accum_scheduler
    import axis_pkg::*;
#(
    parameter int P_COUNT_W  = 16,
    parameter int P_DIV_W    = 23,
    parameter int P_SHIFT    = DEF_SHIFT,
    parameter int P_LIMIT    = DEF_LIMIT,
    parameter int P_DEADBAND = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [P_DIV_W-1:0]          tick_div_in,
    input  logic                        clr_in,
    axis_accum_scheduler_if.slave       smp_if,
    output logic signed [P_COUNT_W-1:0] pos_x_out,
    output logic signed [P_COUNT_W-1:0] pos_y_out,
    output logic signed [P_COUNT_W-1:0] pos_z_out,
    output logic                        tick_out,
    output logic                        upd_valid_out,
    output logic                        busy_out,
    output logic                        overrun_out
);

    // ---------------- tick divider ----------------
    logic [P_DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic               tick_q, tick_d;

    // A period shortened below the current count restarts the count without a tick.
    always_comb begin
        tick_d    = 1'b0;
        div_cnt_d = div_cnt_q + P_DIV_W'(1);
        if (div_cnt_q == tick_div_in) begin
            tick_d    = 1'b1;
            div_cnt_d = '0;
        end else if (div_cnt_q > tick_div_in) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    // ---------------- shared accumulator ----------------
    state_t                      state_q;
    logic                        ready_q;
    logic                        busy_q;
    logic                        upd_q;
    logic                        overrun_q;
    logic signed [P_COUNT_W-1:0] pos_q [3];
    logic signed [P_COUNT_W-1:0] smp_q [3];

    axis_t                       axis_sel;
    logic signed [P_COUNT_W-1:0] acc_pos;
    logic signed [P_COUNT_W-1:0] acc_smp;
    logic signed [P_COUNT_W-1:0] acc_res;

    always_comb begin
        axis_sel = AX_X;
        case (state_q)
            ACC_Y:   axis_sel = AX_Y;
            ACC_Z:   axis_sel = AX_Z;
            default: axis_sel = AX_X;
        endcase
    end

    assign acc_pos = pos_q[axis_sel];
    assign acc_smp = smp_q[axis_sel];

    sat_accum #(
        .P_COUNT_W  (P_COUNT_W),
        .P_SHIFT    (P_SHIFT),
        .P_LIMIT    (P_LIMIT),
        .P_DEADBAND (P_DEADBAND)
    ) u_sat_accum (
        .pos_i    (acc_pos),
        .sample_i (acc_smp),
        .pos_o    (acc_res)
    );

    // ---------------- sequencer ----------------
    // ready/busy/upd are registered alongside the state so they change
    // exactly with the state they describe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            upd_q     <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                pos_q[i] <= '0;
                smp_q[i] <= '0;
            end
        end else if (clr_in) begin
            // Abort: any tick this cycle is swallowed, overrun untouched.
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            upd_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            upd_q <= 1'b0;
            if (tick_q && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        state_q <= WAIT_SMP;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_SMP: begin
                    if (smp_if.sample_valid) begin
                        smp_q[AX_X] <= smp_if.x_axis[P_COUNT_W-1:0];
                        smp_q[AX_Y] <= smp_if.y_axis[P_COUNT_W-1:0];
                        smp_q[AX_Z] <= smp_if.z_axis[P_COUNT_W-1:0];
                        state_q     <= ACC_X;
                        ready_q     <= 1'b0;
                    end
                end
                ACC_X: begin
                    pos_q[AX_X] <= acc_res;
                    state_q     <= ACC_Y;
                end
                ACC_Y: begin
                    pos_q[AX_Y] <= acc_res;
                    state_q     <= ACC_Z;
                end
                ACC_Z: begin
                    pos_q[AX_Z] <= acc_res;
                    state_q     <= DONE;
                    upd_q       <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign smp_if.sample_ready = ready_q;
    assign pos_x_out           = pos_q[AX_X];
    assign pos_y_out           = pos_q[AX_Y];
    assign pos_z_out           = pos_q[AX_Z];
    assign tick_out            = tick_q;
    assign upd_valid_out       = upd_q;
    assign busy_out            = busy_q;
    assign overrun_out         = overrun_q;

endmodule
